conv_layer_sequencer: RTL and testbench

- Sequences one convolution layer over the window-convolution datapath.
- Walks output maps, then output rows, then output columns, issuing one window request per output pixel through a valid/ready handshake.
- Tracks outstanding requests with a credit counter, collects in-order results and writes them linearly into the output feature-map buffer.
- Sits between the layer-level controller (start/done) and the convolution engine plus output memory.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_layer_sequencer_pos_counter.sv | 56 +++++
 rtl/conv_layer_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution layer sequencer.
// Holds the sequencer state encoding and the legal-filter helper.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_t;

    localparam int unsigned IMG_MAX    = 32;
    localparam int unsigned MAX_FILTER = 5;
    localparam int unsigned DW         = 16;

    // Only odd kernels up to MAX_FILTER are supported by the window engine.
    function automatic logic is_legal_filter(input logic [15:0] size);
        return (size == 16'd1) || (size == 16'd3) || (size == 16'd5);
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_pos_counter.sv
// Nested output-position counter: column fastest, then row, then map.
// Advances once per accepted window request; cleared while the sequencer idles.
module conv_pos_counter
    import conv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_fire,
    input  logic [15:0] i_out_dim,
    input  logic [15:0] i_num_maps,
    output logic [15:0] o_row,
    output logic [15:0] o_col,
    output logic [15:0] o_map,
    output logic        o_col_last,
    output logic        o_row_last,
    output logic        o_last
);

    logic [15:0] r_row;
    logic [15:0] r_col;
    logic [15:0] r_map;
    logic        w_map_last;

    assign o_col_last = (r_col == i_out_dim - 16'd1);
    assign o_row_last = (r_row == i_out_dim - 16'd1);
    assign w_map_last = (r_map == i_num_maps - 16'd1);
    assign o_last     = o_col_last && o_row_last && w_map_last;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_row <= '0;
            r_col <= '0;
            r_map <= '0;
        end else if (i_fire) begin
            if (o_col_last) begin
                r_col <= '0;
                if (o_row_last) begin
                    r_row <= '0;
                    r_map <= r_map + 16'd1;
                end else begin
                    r_row <= r_row + 16'd1;
                end
            end else begin
                r_col <= r_col + 16'd1;
            end
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;
    assign o_map = r_map;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Sequences one convolution layer: issues one window request per output pixel,
// bounds in-flight requests with a credit counter and writes results linearly.
module conv_layer_sequencer #(
    parameter int unsigned IMG_MAX  = conv_pkg::IMG_MAX,
    parameter int unsigned DW       = conv_pkg::DW,
    parameter int unsigned MAX_OUT  = 4,
    parameter int unsigned MAPS_MAX = 8,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       img_size,
    input  logic [15:0]       filter_size,
    input  logic [15:0]       num_maps,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [15:0]       req_row,
    output logic [15:0]       req_col,
    output logic [15:0]       req_map,
    input  logic              rsp_valid,
    input  logic [DW-1:0]     rsp_data,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DW-1:0]     out_data
);
    import conv_pkg::*;

    localparam int unsigned     CW         = $clog2(MAX_OUT + 1);
    localparam logic [15:0]     IMG_MAX_W  = 16'(IMG_MAX);
    localparam logic [15:0]     MAPS_MAX_W = 16'(MAPS_MAX);
    localparam logic [CW-1:0]   MAX_OUT_W  = CW'(MAX_OUT);

    seq_state_t        r_state;
    seq_state_t        w_next_state;

    logic [15:0]       r_img;
    logic [15:0]       r_filt;
    logic [15:0]       r_maps;
    logic [15:0]       r_out_dim;
    logic [31:0]       r_total;
    logic [CW-1:0]     r_outstanding;
    logic [31:0]       r_received;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_out_we;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DW-1:0]     r_out_data;
    logic              r_cfg_err;

    logic              w_cfg_ok;
    logic [15:0]       w_out_dim;
    logic [31:0]       w_total;
    logic              w_fire;
    logic              w_rsp_acc;
    logic [31:0]       w_received_next;
    logic              w_clear;
    logic              w_last;
    logic              w_col_last;
    logic              w_row_last;

    assign w_cfg_ok = is_legal_filter(r_filt) && (r_filt <= r_img) && (r_img <= IMG_MAX_W)
                      && (r_maps != 16'd0) && (r_maps <= MAPS_MAX_W);
    assign w_out_dim = r_img - r_filt + 16'd1;
    assign w_total   = 32'(r_maps) * 32'(w_out_dim) * 32'(w_out_dim);

    assign w_fire          = req_valid && req_ready;
    // A response with no credit outstanding is stale (e.g. after reset) and is dropped.
    assign w_rsp_acc       = rsp_valid && (r_outstanding != '0);
    assign w_received_next = r_received + 32'(w_rsp_acc);
    assign w_clear         = (r_state == IDLE);

    conv_pos_counter u_pos (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_fire     (w_fire),
        .i_out_dim  (r_out_dim),
        .i_num_maps (r_maps),
        .o_row      (req_row),
        .o_col      (req_col),
        .o_map      (req_map),
        .o_col_last (w_col_last),
        .o_row_last (w_row_last),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next_state = CHECK;
            CHECK:   w_next_state = w_cfg_ok ? ISSUE : IDLE;
            ISSUE:   if (w_fire && w_last) w_next_state = DRAIN;
            DRAIN:   if (w_received_next == r_total) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        req_valid = 1'b0;
        unique case (r_state)
            ISSUE: begin
                busy      = 1'b1;
                req_valid = (r_outstanding < MAX_OUT_W);
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_img         <= '0;
            r_filt        <= '0;
            r_maps        <= '0;
            r_out_dim     <= '0;
            r_total       <= '0;
            r_outstanding <= '0;
            r_received    <= '0;
            r_wr_ptr      <= '0;
            r_out_we      <= 1'b0;
            r_out_addr    <= '0;
            r_out_data    <= '0;
            r_cfg_err     <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_img  <= img_size;
                r_filt <= filter_size;
                r_maps <= num_maps;
            end

            r_cfg_err <= (r_state == CHECK) && !w_cfg_ok;
            if (r_state == CHECK) begin
                r_out_dim <= w_out_dim;
                r_total   <= w_total;
            end

            unique case ({w_fire, w_rsp_acc})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            r_out_we <= w_rsp_acc;
            if (w_rsp_acc) begin
                r_out_data <= rsp_data;
                r_out_addr <= r_wr_ptr;
                r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
            end
            r_received <= w_received_next;

            if (r_state == IDLE) begin
                r_wr_ptr   <= '0;
                r_received <= '0;
            end
        end
    end

    assign out_we   = r_out_we;
    assign out_addr = r_out_addr;
    assign out_data = r_out_data;
    assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized self-checking bench for conv_layer_sequencer: a queue-based model
// of the expected request order, an in-order responder and the linear write image.
module tb_conv_layer_sequencer;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] img_size;
    logic [15:0] filter_size;
    logic [15:0] num_maps;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_row;
    logic [15:0] req_col;
    logic [15:0] req_map;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        out_we;
    logic [15:0] out_addr;
    logic [15:0] out_data;

    always #5 clk = ~clk;

    conv_layer_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .img_size    (img_size),
        .filter_size (filter_size),
        .num_maps    (num_maps),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_row     (req_row),
        .req_col     (req_col),
        .req_map     (req_map),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .out_we      (out_we),
        .out_addr    (out_addr),
        .out_data    (out_data)
    );

    typedef struct {int map; int row; int col;} pos_t;
    typedef struct {int due; logic [15:0] data;} rsp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    pos_t        exp_req_q[$];
    rsp_t        pend_q[$];
    logic [15:0] exp_wr_q[$];
    int          exp_addr;
    int          n_fire, n_wr, n_done, n_cfg_err, n_busy_seen, n_rv_seen, n_coinc;
    int          model_out;
    int          err_cyc;
    int          rmode = 0;       // 0: always ready, 1: random, 2: never
    int          lat_min = 2, lat_max = 2;
    int          dmode = 0;       // 0: row*10+col, 1: random data
    bit          rsp_en = 1'b1;
    bit          stale_mode = 1'b0;
    bit          stalled = 1'b0;
    pos_t        held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic clear_stats();
        n_fire = 0; n_wr = 0; n_done = 0; n_cfg_err = 0;
        n_busy_seen = 0; n_rv_seen = 0; n_coinc = 0;
        model_out = 0; err_cyc = -1; stalled = 1'b0;
        exp_req_q.delete(); pend_q.delete(); exp_wr_q.delete();
        exp_addr = 0;
    endtask

    // One clock: observe outputs at the falling edge, then drive the next inputs.
    task automatic cycle();
        pos_t        p;
        rsp_t        r;
        logic [15:0] d;
        bit          sent;
        @(negedge clk);
        cyc++;
        if (out_we) begin
            n_wr++;
            if (exp_wr_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                d = exp_wr_q.pop_front();
                check("wr_addr", 32'(out_addr), exp_addr);
                check("wr_data", 32'(out_data), 32'(d));
                exp_addr++;
            end
        end
        if (done) n_done++;
        if (cfg_err) begin n_cfg_err++; err_cyc = cyc; end
        if (busy) n_busy_seen++;
        if (req_valid) n_rv_seen++;
        if (stalled) begin
            check("hold_valid", 32'(req_valid), 1);
            check("hold_row", 32'(req_row), held.row);
            check("hold_col", 32'(req_col), held.col);
            check("hold_map", 32'(req_map), held.map);
        end

        sent = 1'b0;
        if (stale_mode) begin
            rsp_valid = 1'b1;
            rsp_data  = 16'($urandom);
        end else if (rsp_en && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            r = pend_q.pop_front();
            rsp_valid = 1'b1;
            rsp_data  = r.data;
            exp_wr_q.push_back(r.data);
            model_out--;
            sent = 1'b1;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 16'($urandom);
        end

        case (rmode)
            0:       req_ready = 1'b1;
            1:       req_ready = 1'($urandom_range(0, 1));
            default: req_ready = 1'b0;
        endcase

        if (req_valid && req_ready) begin
            n_fire++;
            if (sent) n_coinc++;
            if (exp_req_q.size() == 0) begin
                check("extra_request", 1, 0);
            end else begin
                p = exp_req_q.pop_front();
                check("req_row", 32'(req_row), p.row);
                check("req_col", 32'(req_col), p.col);
                check("req_map", 32'(req_map), p.map);
                r.due  = cyc + $urandom_range(lat_min, lat_max);
                r.data = (dmode == 0) ? 16'(p.row * 10 + p.col) : 16'($urandom);
                pend_q.push_back(r);
            end
            model_out++;
            check("credit_cap", 32'(model_out <= MAX_OUT), 1);
        end
        stalled = req_valid && !req_ready;
        held.row = req_row; held.col = req_col; held.map = req_map;
    endtask

    task automatic begin_layer(input int img, input int filt, input int maps);
        int od;
        pos_t p;
        clear_stats();
        od = img - filt + 1;
        for (int m = 0; m < maps; m++)
            for (int r = 0; r < od; r++)
                for (int c = 0; c < od; c++) begin
                    p.map = m; p.row = r; p.col = c;
                    exp_req_q.push_back(p);
                end
        img_size = 16'(img); filter_size = 16'(filt); num_maps = 16'(maps);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic finish_layer(input int total, input bit extra_start);
        int img_keep;
        img_keep = int'(img_size);
        for (int i = 0; i < 20000 && n_done == 0; i++) begin
            if (extra_start && i == 5) begin
                start = 1'b1;
                img_size = 16'd3;
            end
            cycle();
            start = 1'b0;
            img_size = 16'(img_keep);
        end
        if (n_done == 0) check("layer_timeout", 0, 1);
        check("busy_at_done", 32'(busy), 0);
        repeat (3) cycle();
        check("fires", n_fire, total);
        check("writes", n_wr, total);
        check("done_count", n_done, 1);
        check("busy_after", 32'(busy), 0);
        check("no_cfg_err", n_cfg_err, 0);
        check("busy_seen", 32'(n_busy_seen > 0), 1);
        check("req_left", exp_req_q.size(), 0);
        if (extra_start) check("coincident_seen", 32'(n_coinc > 0), 1);
    endtask

    task automatic run_layer(input int img, input int filt, input int maps, input bit extra_start);
        int od;
        od = img - filt + 1;
        begin_layer(img, filt, maps);
        finish_layer(maps * od * od, extra_start);
    endtask

    task automatic run_bad(input int img, input int filt, input int maps);
        int s;
        clear_stats();
        img_size = 16'(img); filter_size = 16'(filt); num_maps = 16'(maps);
        s = cyc;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (6) cycle();
        check("cfg_err_count", n_cfg_err, 1);
        check("cfg_err_latency", err_cyc - s, 2);
        check("bad_busy", n_busy_seen, 0);
        check("bad_req_valid", n_rv_seen, 0);
        check("bad_done", n_done, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 0);
        check({tag, "_req_valid"}, 32'(req_valid), 0);
        check({tag, "_out_we"}, 32'(out_we), 0);
        check({tag, "_req_pos"}, {req_row[7:0], req_col[7:0], req_map[7:0]}, 0);
        check({tag, "_out_addr"}, 32'(out_addr), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        img_size = '0; filter_size = '0; num_maps = '0;
        clear_stats();
        repeat (3) cycle();
        check_all_zero("reset");
        reset = 1'b0;
        cycle();

        // Basic 3x3 output, fixed latency 2, data row*10+col.
        rmode = 0; lat_min = 2; lat_max = 2; dmode = 0;
        run_layer(5, 3, 1, 1'b0);

        // Credit limit: no responses until released.
        rsp_en = 1'b0; dmode = 1;
        begin_layer(4, 3, 2);
        repeat (20) cycle();
        check("credit_fires", n_fire, MAX_OUT);
        check("credit_valid_low", 32'(req_valid), 0);
        check("credit_no_write", n_wr, 0);
        rsp_en = 1'b1;
        finish_layer(8, 1'b0);

        // Random back-pressure and latency.
        rmode = 1; lat_min = 1; lat_max = 4;
        run_layer(6, 3, 2, 1'b0);
        run_layer(7, 5, 8, 1'b0);
        rmode = 0;
        run_layer(1, 1, 1, 1'b0);
        run_layer(32, 1, 1, 1'b0);

        // Illegal configurations.
        run_bad(5, 4, 1);
        run_bad(3, 5, 1);
        run_bad(5, 3, 0);
        run_bad(33, 3, 1);
        run_bad(5, 3, 9);

        // Reset during ISSUE, then stale responses, then a fresh minimal layer.
        rmode = 0; lat_min = 10; lat_max = 10;
        begin_layer(5, 3, 1);
        for (int i = 0; i < 50 && n_fire < 3; i++) cycle();
        check("pre_reset_fires", n_fire, 3);
        rmode = 2;
        cycle();
        reset = 1'b1;
        stalled = 1'b0;
        cycle();
        check_all_zero("midreset");
        reset = 1'b0;
        clear_stats();
        stale_mode = 1'b1;
        repeat (4) cycle();
        stale_mode = 1'b0;
        repeat (2) cycle();
        check("stale_writes", n_wr, 0);
        rmode = 0; lat_min = 2; lat_max = 2; dmode = 0;
        run_layer(3, 3, 1, 1'b0);

        // Second start while busy, with responses coinciding with fires.
        run_layer(5, 3, 2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
